clk_rst_seq: RTL and testbench

Parametrised clock-enable and reset sequencer serving the dashcam SoC's clock-and-reset domain. It generates NUM_CH independently programmable divided clocks, each with a matching one-cycle enable strobe. It also releases NUM_CH active-low domain resets one after another at a programmable spacing. Software can restart the reset sequence at any time without stopping the clocks.

---
 rtl/clk_rst_pkg.sv | 17 +
 rtl/clk_div_ch.sv | 53 +++++
 rtl/clk_rst_seq.sv | 123 ++++++++++++
 tb/tb_clk_rst_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared encodings and helpers for the clock-enable / reset sequencer.
package clk_rst_pkg;

  localparam int unsigned SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DONE   = 2'd2
  } seq_state_e;

  // A programmed zero means "as fast as possible", i.e. one.
  function automatic logic [31:0] clamp_min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// Single-channel divider: sys_clk toggles every N enabled cycles, clk_en marks each rise.
module clk_div_ch
  import clk_rst_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sys_clk,
  output logic             clk_en
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_last;
  logic             sys_clk_q, sys_clk_d;
  logic             clk_en_q, clk_en_d;

  // >= rather than == so a lowered ratio takes effect immediately.
  always_comb begin
    n_last    = DIV_W'(clamp_min1(32'(div)) - 32'd1);
    cnt_d     = cnt_q;
    sys_clk_d = sys_clk_q;
    clk_en_d  = 1'b0;
    if (!en) begin
      cnt_d     = '0;
      sys_clk_d = 1'b0;
    end else if (cnt_q >= n_last) begin
      cnt_d     = '0;
      sys_clk_d = ~sys_clk_q;
      clk_en_d  = ~sys_clk_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q     <= '0;
      sys_clk_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sys_clk_q <= sys_clk_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign sys_clk = sys_clk_q;
  assign clk_en  = clk_en_q;

endmodule

// File: rtl/clk_rst_seq.sv
// NUM_CH programmable clock dividers plus a sequencer releasing domain resets
// in channel order at a programmable spacing.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned DLY_W  = 16
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic [DLY_W-1:0]        rst_dly,
  input  logic                    sw_rst_req,
  output logic [NUM_CH-1:0]       sys_clk,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       sys_reset_n,
  output logic                    seq_done,
  output logic [SEQ_STATE_W-1:0]  seq_state
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_div
    clk_div_ch #(.DIV_W(DIV_W)) u_div (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .en       (ch_en[c]),
      .div      (div_cfg[c*DIV_W +: DIV_W]),
      .sys_clk  (sys_clk[c]),
      .clk_en   (clk_en[c])
    );
  end

  seq_state_e        state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    dly_cnt_d = dly_cnt_q;
    idx_d     = idx_q;
    rst_n_d   = rst_n_q;
    done_d    = done_q;
    case (state_q)
      ST_ASSERT: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        idx_d   = '0;
        // Spacing is captured once per sequence; later rst_dly changes wait.
        if (!sw_rst_req) begin
          dly_d     = DLY_W'(clamp_min1(32'(rst_dly)));
          dly_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sw_rst_req) begin
          state_d   = ST_ASSERT;
          rst_n_d   = '0;
          done_d    = 1'b0;
          idx_d     = '0;
          dly_cnt_d = '0;
        end else if (dly_cnt_q == dly_q - DLY_W'(1)) begin
          rst_n_d[idx_q] = 1'b1;
          dly_cnt_d      = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end
      ST_DONE: begin
        if (sw_rst_req) begin
          state_d   = ST_ASSERT;
          rst_n_d   = '0;
          done_d    = 1'b0;
          idx_d     = '0;
          dly_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        rst_n_d = '0;
        done_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= ST_ASSERT;
      dly_q     <= '0;
      dly_cnt_q <= '0;
      idx_q     <= '0;
      rst_n_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      dly_cnt_q <= dly_cnt_d;
      idx_q     <= idx_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
    end
  end

  assign sys_reset_n = rst_n_q;
  assign seq_done    = done_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Randomized bench for clk_rst_seq against an edge-timestamp reference model.
module tb_clk_rst_seq;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DLY_W  = 16;

  logic                    clk_in = 1'b0;
  logic                    reset_in;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic [DLY_W-1:0]        rst_dly;
  logic                    sw_rst_req;
  logic [NUM_CH-1:0]       sys_clk;
  logic [NUM_CH-1:0]       clk_en;
  logic [NUM_CH-1:0]       sys_reset_n;
  logic                    seq_done;
  logic [1:0]              seq_state;

  clk_rst_seq #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DLY_W(DLY_W)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .ch_en       (ch_en),
    .div_cfg     (div_cfg),
    .rst_dly     (rst_dly),
    .sw_rst_req  (sw_rst_req),
    .sys_clk     (sys_clk),
    .clk_en      (clk_en),
    .sys_reset_n (sys_reset_n),
    .seq_done    (seq_done),
    .seq_state   (seq_state)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model: everything is expressed as edge numbers.
  int edge_n = 0;
  bit in_seq = 1'b0;
  int e0     = 0;
  int d_m    = 1;
  int mark [NUM_CH];
  logic [NUM_CH-1:0] clk_m = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  // Advance one edge, update the model from the inputs the DUT just sampled, compare.
  task automatic step();
    logic [NUM_CH-1:0] exp_rst;
    logic [NUM_CH-1:0] exp_en;
    logic              exp_done;
    logic [1:0]        exp_state;
    int                el;
    int                n;
    @(posedge clk_in);
    #1;
    edge_n++;

    if (reset_in || sw_rst_req) begin
      in_seq = 1'b0;
    end else if (!in_seq) begin
      in_seq = 1'b1;
      e0     = edge_n;
      d_m    = (rst_dly == '0) ? 1 : int'(rst_dly);
    end
    exp_rst   = '0;
    exp_done  = 1'b0;
    exp_state = 2'd0;
    if (in_seq) begin
      el = edge_n - e0;
      for (int k = 0; k < NUM_CH; k++) exp_rst[k] = (el >= (k + 1) * d_m);
      exp_done  = (el >= NUM_CH * d_m);
      exp_state = exp_done ? 2'd2 : 2'd1;
    end

    exp_en = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      n = int'(div_cfg[c*DIV_W +: DIV_W]);
      if (n == 0) n = 1;
      if (reset_in || !ch_en[c]) begin
        clk_m[c] = 1'b0;
        mark[c]  = edge_n;
      end else if (edge_n - mark[c] >= n) begin
        clk_m[c]  = ~clk_m[c];
        mark[c]   = edge_n;
        exp_en[c] = clk_m[c];
      end
    end

    chk("sys_clk", 32'(sys_clk), 32'(clk_m));
    chk("clk_en", 32'(clk_en), 32'(exp_en));
    chk("sys_reset_n", 32'(sys_reset_n), 32'(exp_rst));
    chk("seq_done", 32'(seq_done), 32'(exp_done));
    chk("seq_state", 32'(seq_state), 32'(exp_state));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) mark[c] = 0;
    reset_in   = 1'b1;
    sw_rst_req = 1'b0;
    ch_en      = '1;
    div_cfg    = {16'd8, 16'd0, 16'd3, 16'd1};
    rst_dly    = 16'd3;
    run(3);
    chk("reset_rst_n", 32'(sys_reset_n), 32'h0);
    chk("reset_clk", 32'(sys_clk), 32'h0);

    // Release at E0; resets should open every 3 edges.
    reset_in = 1'b0;
    step();
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i % 3 == 0) chk("plan_release", 32'(sys_reset_n), (32'd1 << (i / 3)) - 32'd1);
    end
    chk("plan_done", 32'(seq_done), 32'd1);
    run(20);

    // Software re-sequence after two channels are out, with zero spacing next time.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    run(7);
    sw_rst_req = 1'b1;
    rst_dly    = 16'd0;
    step();
    chk("sw_assert", 32'(sys_reset_n), 32'h0);
    sw_rst_req = 1'b0;
    run(3);
    rst_dly = 16'd9;
    run(10);

    // Shrink channel 3 from 8 to 2 mid-count.
    run(5);
    div_cfg[3*DIV_W +: DIV_W] = 16'd2;
    run(30);

    // Reset mid-DONE, channel 2 disabled afterwards.
    reset_in = 1'b1;
    ch_en    = 4'b1011;
    step();
    chk("mid_reset", 32'({sys_clk, clk_en, sys_reset_n, seq_done}), 32'h0);
    reset_in = 1'b0;
    run(40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sw_rst_req = ($urandom_range(0, 39) == 0);
      reset_in   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) ch_en = NUM_CH'($urandom);
      if ($urandom_range(0, 99) == 0)
        div_cfg[$urandom_range(0, NUM_CH - 1)*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) rst_dly = DLY_W'($urandom_range(0, 4));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
